sop_sweep_ctrl: RTL and testbench



---
 rtl/sop_sweep_ctrl.sv | 157 +++++++++++++++
 tb/tb_sop_sweep_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sop_sweep_ctrl.sv
// Sweeps a 4-input function through all 16 minterms and captures its truth table.
// Optional comparator against an expected table: define SOP_SWEEP_COMPARE_EN.
module sop_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        s_in,
    input  logic [15:0] expected,
    output logic        x,
    output logic        y,
    output logic        w,
    output logic        z,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        match,
    output logic [3:0]  fail_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tt_q, tt_d;
    logic        match_q, match_d;
    logic [3:0]  fail_q, fail_d;

    logic [15:0] tt_cap;
    logic        cmp_match;
    logic [3:0]  cmp_idx;
    logic [3:0]  vec;

    // Table as it will look once the current minterm is captured; the
    // comparator looks at this so match/fail_idx land together with DONE.
    always_comb begin
        tt_cap         = tt_q;
        tt_cap[idx_q]  = s_in;
    end

`ifdef SOP_SWEEP_COMPARE_EN
    logic [15:0] diff;

    always_comb begin
        diff      = tt_cap ^ expected;
        cmp_match = (diff == '0);
        cmp_idx   = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (diff[i-1]) begin
                cmp_idx = 4'(i - 1);
            end
        end
    end
`else
    logic unused_expected;

    assign unused_expected = ^expected;
    assign cmp_match       = 1'b0;
    assign cmp_idx         = '0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        match_d = match_q;
        fail_d  = fail_q;
        busy    = 1'b0;
        done    = 1'b0;
        vec     = '0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
                    match_d = 1'b0;
                    fail_d  = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                vec  = idx_q;
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                vec  = idx_q;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    tt_d = tt_cap;
                    if (idx_q == 4'd15) begin
                        match_d = cmp_match;
                        fail_d  = cmp_idx;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            match_q <= 1'b0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            match_q <= match_d;
            fail_q  <= fail_d;
        end
    end

    assign {x, y, w, z} = vec;
    assign tt           = tt_q;
    assign match        = match_q;
    assign fail_idx     = fail_q;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Directed bench for sop_sweep_ctrl: table-driven full sweeps plus abort/reset/start corner cases.
module tb_sop_sweep_ctrl;

`ifdef SOP_SWEEP_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_a, start_b, abort;
    logic [15:0] expected;

    logic        xa, ya, wa, za, busy_a, done_a, match_a;
    logic [15:0] tt_a;
    logic [3:0]  fi_a;
    logic        xb, yb, wb, zb, busy_b, done_b, match_b;
    logic [15:0] tt_b;
    logic [3:0]  fi_b;
    logic        s_a, s_b;

    function automatic logic f_model(input logic [3:0] m);
        logic fx, fy, fw, fz;
        {fx, fy, fw, fz} = m;
        return (~fx & fy & ~fw) | (fx & fy & fz) | (~fy & fw);
    endfunction

    assign s_a = f_model({xa, ya, wa, za});
    assign s_b = f_model({xb, yb, wb, zb});

    sop_sweep_ctrl #(.SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .s_in(s_a),
        .expected(expected), .x(xa), .y(ya), .w(wa), .z(za), .busy(busy_a),
        .done(done_a), .tt(tt_a), .match(match_a), .fail_idx(fi_a)
    );

    sop_sweep_ctrl #(.SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .s_in(s_b),
        .expected(expected), .x(xb), .y(yb), .w(wb), .z(zb), .busy(busy_b),
        .done(done_b), .tt(tt_b), .match(match_b), .fail_idx(fi_b)
    );

    int unsigned sel;
    logic        cur_busy, cur_done, cur_match;
    logic [15:0] cur_tt;
    logic [3:0]  cur_fi, cur_vec;

    always_comb begin
        if (sel == 0) begin
            cur_busy = busy_a; cur_done = done_a; cur_match = match_a;
            cur_tt = tt_a; cur_fi = fi_a; cur_vec = {xa, ya, wa, za};
        end else begin
            cur_busy = busy_b; cur_done = done_b; cur_match = match_b;
            cur_tt = tt_b; cur_fi = fi_b; cur_vec = {xb, yb, wb, zb};
        end
    end

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int unsigned s, input logic v);
        if (s == 0) start_a = v;
        else        start_b = v;
    endtask

    task automatic run_sweep(input int unsigned s, input logic [15:0] exp_tab,
                             input logic [15:0] exp_tt, input logic exp_m,
                             input logic [3:0] exp_fi, input int unsigned settle,
                             input int unsigned stray_at, input bit start_in_done,
                             input string tag);
        int unsigned edges;
        int unsigned vec_bad;
        int unsigned extra;
        sel      = s;
        expected = exp_tab;
        @(negedge clk);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        edges   = 0;
        vec_bad = 0;
        while (edges < 200) begin
            if (cur_done) break;
            if (cur_vec !== 4'(edges / (settle + 1)) || cur_busy !== 1'b1) vec_bad++;
            set_start(s, stray_at != 0 && edges == stray_at);
            @(negedge clk);
            edges++;
        end
        set_start(s, 1'b0);
        check({tag, " latency"}, edges, 16 * (settle + 1));
        check({tag, " vector/busy sequence errors"}, vec_bad, 0);
        check({tag, " tt"}, cur_tt, exp_tt);
        check({tag, " match"}, cur_match, exp_m);
        check({tag, " fail_idx"}, cur_fi, exp_fi);
        if (start_in_done) set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        check({tag, " busy after done"}, cur_busy, 1'b0);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (cur_done || cur_busy) extra++;
        end
        check({tag, " activity after done"}, extra, 0);
        check({tag, " match held"}, cur_match, exp_m);
        check({tag, " tt held"}, cur_tt, exp_tt);
    endtask

    typedef struct {
        logic [15:0] exp_in;
        logic        exp_m;
        logic [3:0]  exp_fi;
        int unsigned stray_at;
        bit          start_in_done;
    } vec_t;

    vec_t        tab[5];
    logic [15:0] golden;

    initial begin
        int unsigned waited;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        expected = '0; sel = 0;
        for (int m = 0; m < 16; m++) golden[m] = f_model(4'(m));

        tab[0] = '{golden,            1'b1, 4'd0,  0, 1'b0};
        tab[1] = '{golden ^ 16'h0001, 1'b0, 4'd0,  7, 1'b1};
        tab[2] = '{golden ^ 16'h8000, 1'b0, 4'd15, 0, 1'b1};
        tab[3] = '{golden ^ 16'h0110, 1'b0, 4'd4,  3, 1'b0};
        tab[4] = '{golden ^ 16'h0800, 1'b0, 4'd11, 0, 1'b0};

        #12;
        check("reset vector a", {xa, ya, wa, za}, 4'h0);
        check("reset busy a", busy_a, 1'b0);
        check("reset done a", done_a, 1'b0);
        check("reset tt a", tt_a, 16'h0);
        check("reset match a", match_a, 1'b0);
        check("reset fail_idx a", fi_a, 4'h0);
        check("reset busy/done b", {busy_b, done_b}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_sweep(0, tab[i].exp_in, golden, CMP ? tab[i].exp_m : 1'b0,
                      CMP ? tab[i].exp_fi : 4'd0, 1, tab[i].stray_at,
                      tab[i].start_in_done, $sformatf("vec%0d", i));
        end

        // abort while minterm 4 is settling
        sel = 0; expected = golden;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (8) @(negedge clk);
        check("abort pre vector", cur_vec, 4'd4);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort busy", cur_busy, 1'b0);
        check("abort done", cur_done, 1'b0);
        check("abort tt partial", cur_tt, golden & 16'h000F);
        check("abort vector", cur_vec, 4'd0);
        check("abort match", cur_match, 1'b0);
        waited = 0;
        repeat (40) begin
            @(negedge clk);
            if (cur_done || cur_busy) waited++;
        end
        check("abort no later activity", waited, 0);

        // start and abort together in IDLE: abort wins
        @(negedge clk); start_a = 1'b1; abort = 1'b1;
        @(negedge clk); start_a = 1'b0; abort = 1'b0;
        check("start+abort busy", cur_busy, 1'b0);
        check("start+abort tt untouched", cur_tt, golden & 16'h000F);

        // asynchronous reset mid-sweep
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (20) @(negedge clk);
        check("pre-reset vector", cur_vec, 4'd10);
        #2 rst_n = 1'b0;
        #1;
        check("async reset vector", cur_vec, 4'd0);
        check("async reset busy/done", {cur_busy, cur_done}, 2'b00);
        check("async reset tt", cur_tt, 16'h0);
        check("async reset match/fail_idx", {cur_match, cur_fi}, 5'h0);
        @(negedge clk); rst_n = 1'b1;
        run_sweep(0, golden, golden, CMP, 4'd0, 1, 0, 1'b0, "post-reset");

        run_sweep(1, golden, golden, CMP, 4'd0, 3, 0, 1'b0, "settle3");
        run_sweep(1, golden ^ 16'h0004, golden, 1'b0, CMP ? 4'd2 : 4'd0, 3, 9, 1'b1, "settle3 mism");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
